// File: rtl/mb_sequencer.sv
// mb_sequencer
// Raster-order macroblock scan sequencer for the intra-prediction loop.
// On a frame request it presents each macroblock in turn and hands it over
// with a valid/ready handshake. It then waits for the loop's completion
// pulse before it advances to the next macroblock.
//
// Parameters:
//   MB_W   frame width in macroblocks (1..127)
//   MB_H   frame height in macroblocks (1..127)
//   NUM_W  width of mbnumber
// Ports:
//   clk            single clock, all state on the rising edge
//   reset          asynchronous, active-low reset
//   enable         issue enable; low stalls new issues (not completions)
//   frame_start    single-cycle request to scan one frame
//   mb_ready       downstream loop can accept a macroblock
//   mb_done        single-cycle pulse: current macroblock finished
//   mb_valid       mbnumber/position/flags are offered for handoff
//   mbnumber       raster macroblock index (all ones when idle)
//   mbx, mby       macroblock column and row
//   avail_*        neighbour availability flags for the current macroblock
//   frame_busy     frame scan in progress
//   frame_done     one-cycle pulse after the last macroblock completes
module mb_sequencer #(
    parameter int MB_W  = 120,
    parameter int MB_H  = 68,
    parameter int NUM_W = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             frame_start,
    input  logic             mb_ready,
    input  logic             mb_done,
    output logic             mb_valid,
    output logic [NUM_W-1:0] mbnumber,
    output logic [6:0]       mbx,
    output logic [6:0]       mby,
    output logic             avail_left,
    output logic             avail_top,
    output logic             avail_topleft,
    output logic             avail_topright,
    output logic             frame_busy,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [NUM_W-1:0] LAST_MB = NUM_W'(MB_W * MB_H - 1);
    localparam logic [6:0]       LAST_X  = 7'(MB_W - 1);

    state_t           state;
    state_t           next_state;
    logic [NUM_W-1:0] next_num;
    logic [6:0]       next_x;
    logic [6:0]       next_y;

    // State, counters and flags. The flags are derived from the next
    // position so they always describe the macroblock being presented,
    // and they change on the same edge as the counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            mbnumber       <= '1;
            mbx            <= '0;
            mby            <= '0;
            avail_left     <= 1'b0;
            avail_top      <= 1'b0;
            avail_topleft  <= 1'b0;
            avail_topright <= 1'b0;
        end else begin
            state          <= next_state;
            mbnumber       <= next_num;
            mbx            <= next_x;
            mby            <= next_y;
            avail_left     <= (next_x != 7'd0);
            avail_top      <= (next_y != 7'd0);
            avail_topleft  <= (next_y != 7'd0) && (next_x != 7'd0);
            avail_topright <= (next_y != 7'd0) && (next_x != LAST_X);
        end
    end

    // Next-state and counter logic. Everything holds by default. In WAIT
    // a completion is taken regardless of enable so that it is never lost.
    always_comb begin
        next_state = state;
        next_num   = mbnumber;
        next_x     = mbx;
        next_y     = mby;
        unique case (state)
            ST_IDLE: begin
                if (frame_start && enable) begin
                    next_num   = '0;
                    next_x     = '0;
                    next_y     = '0;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (enable && mb_ready) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mb_done) begin
                    if (mbnumber == LAST_MB) begin
                        next_state = ST_DONE;
                    end else begin
                        next_num   = mbnumber + NUM_W'(1);
                        next_state = ST_ISSUE;
                        if (mbx == LAST_X) begin
                            next_x = '0;
                            next_y = mby + 7'd1;
                        end else begin
                            next_x = mbx + 7'd1;
                        end
                    end
                end
            end
            ST_DONE: begin
                next_num   = '1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Handshake and framing outputs decode straight from the state register.
    // This keeps them consistent with an asynchronous reset.
    always_comb begin
        mb_valid   = (state == ST_ISSUE) && enable;
        frame_busy = (state == ST_ISSUE) || (state == ST_WAIT);
        frame_done = (state == ST_DONE);
    end

endmodule

// File: tb/tb_mb_sequencer.sv
// tb_mb_sequencer
// Directed bench for mb_sequencer. One instance runs a 3x2 frame and covers
// the scan order, flags, backpressure, enable stall, spurious inputs and
// mid-frame reset. A second instance runs a 1x1 frame for the degenerate case.
module tb_mb_sequencer;

    localparam logic [12:0] NO_MB = 13'h1fff;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        frame_start;
    logic        mb_ready;
    logic        mb_done;
    logic        mb_valid;
    logic [12:0] mbnumber;
    logic [6:0]  mbx;
    logic [6:0]  mby;
    logic        avail_left;
    logic        avail_top;
    logic        avail_topleft;
    logic        avail_topright;
    logic        frame_busy;
    logic        frame_done;

    logic        d_frame_start;
    logic        d_mb_ready;
    logic        d_mb_done;
    logic        d_mb_valid;
    logic [12:0] d_mbnumber;
    logic [6:0]  d_mbx;
    logic [6:0]  d_mby;
    logic        d_avail_left;
    logic        d_avail_top;
    logic        d_avail_topleft;
    logic        d_avail_topright;
    logic        d_frame_busy;
    logic        d_frame_done;

    int check_count = 0;
    int error_count = 0;

    always #5 clk = ~clk;

    mb_sequencer #(.MB_W(3), .MB_H(2), .NUM_W(13)) dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
        .mb_ready(mb_ready), .mb_done(mb_done), .mb_valid(mb_valid),
        .mbnumber(mbnumber), .mbx(mbx), .mby(mby),
        .avail_left(avail_left), .avail_top(avail_top),
        .avail_topleft(avail_topleft), .avail_topright(avail_topright),
        .frame_busy(frame_busy), .frame_done(frame_done)
    );

    mb_sequencer #(.MB_W(1), .MB_H(1), .NUM_W(13)) dut_one (
        .clk(clk), .reset(reset), .enable(enable), .frame_start(d_frame_start),
        .mb_ready(d_mb_ready), .mb_done(d_mb_done), .mb_valid(d_mb_valid),
        .mbnumber(d_mbnumber), .mbx(d_mbx), .mby(d_mby),
        .avail_left(d_avail_left), .avail_top(d_avail_top),
        .avail_topleft(d_avail_topleft), .avail_topright(d_avail_topright),
        .frame_busy(d_frame_busy), .frame_done(d_frame_done)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive the main instance's inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic en, input logic fs, input logic rdy, input logic done);
        enable      = en;
        frame_start = fs;
        mb_ready    = rdy;
        mb_done     = done;
        #1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Expected position and flags for raster index n in a 3-wide frame.
    task automatic checkPosition(input int n);
        int x;
        int y;
        x = n % 3;
        y = n / 3;
        checkOutput($sformatf("mb%0d valid", n), mb_valid, 1);
        checkOutput($sformatf("mb%0d busy", n), frame_busy, 1);
        checkOutput($sformatf("mb%0d number", n), mbnumber, n);
        checkOutput($sformatf("mb%0d mbx", n), mbx, x);
        checkOutput($sformatf("mb%0d mby", n), mby, y);
        checkOutput($sformatf("mb%0d left", n), avail_left, (x != 0));
        checkOutput($sformatf("mb%0d top", n), avail_top, (y != 0));
        checkOutput($sformatf("mb%0d topleft", n), avail_topleft, (x != 0 && y != 0));
        checkOutput($sformatf("mb%0d topright", n), avail_topright, (y != 0 && x != 2));
    endtask

    // Present, hand over, then complete two cycles after the handoff.
    task automatic runMacroblock(input int n);
        checkPosition(n);
        applyStimulus(1, 0, 1, 0);
        cycle();
        applyStimulus(1, 0, 0, 0);
        checkOutput($sformatf("mb%0d valid after handoff", n), mb_valid, 0);
        checkOutput($sformatf("mb%0d number in wait", n), mbnumber, n);
        cycle();
        applyStimulus(1, 0, 0, 1);
        cycle();
        applyStimulus(1, 0, 0, 0);
    endtask

    initial begin
        reset         = 1'b0;
        d_frame_start = 1'b0;
        d_mb_ready    = 1'b0;
        d_mb_done     = 1'b0;
        applyStimulus(0, 0, 0, 0);
        #11;
        checkOutput("reset number", mbnumber, NO_MB);
        checkOutput("reset mbx", mbx, 0);
        checkOutput("reset mby", mby, 0);
        checkOutput("reset flags", {avail_left, avail_top, avail_topleft, avail_topright}, 0);
        checkOutput("reset valid", mb_valid, 0);
        checkOutput("reset busy", frame_busy, 0);
        checkOutput("reset done", frame_done, 0);
        reset = 1'b1;
        cycle();

        // Spurious mb_done in IDLE.
        applyStimulus(1, 0, 1, 1);
        cycle();
        applyStimulus(1, 0, 0, 0);
        checkOutput("idle done ignored busy", frame_busy, 0);
        checkOutput("idle done ignored number", mbnumber, NO_MB);

        // frame_start with enable low is dropped.
        applyStimulus(0, 1, 0, 0);
        cycle();
        applyStimulus(0, 0, 0, 0);
        checkOutput("start dropped busy", frame_busy, 0);
        checkOutput("start dropped number", mbnumber, NO_MB);

        // Real frame start.
        applyStimulus(1, 1, 0, 0);
        cycle();
        applyStimulus(1, 0, 0, 0);

        // Spurious frame_start and mb_done in ISSUE.
        applyStimulus(1, 1, 0, 1);
        cycle();
        applyStimulus(1, 0, 0, 0);
        checkOutput("issue spurious valid", mb_valid, 1);
        checkOutput("issue spurious number", mbnumber, 0);

        runMacroblock(0);

        // Enable stall in ISSUE at MB 1: no handoff despite mb_ready.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 0);
            checkOutput($sformatf("stall%0d valid", i), mb_valid, 0);
            cycle();
        end
        applyStimulus(1, 0, 0, 0);
        checkPosition(1);
        applyStimulus(1, 0, 1, 0);
        cycle();
        // In WAIT with enable low and a spurious frame_start.
        applyStimulus(0, 1, 0, 0);
        checkOutput("wait valid", mb_valid, 0);
        checkOutput("wait busy", frame_busy, 1);
        cycle();
        applyStimulus(0, 0, 0, 1);
        cycle();
        applyStimulus(1, 0, 0, 0);

        // Backpressure at MB 2.
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("bp%0d valid", i), mb_valid, 1);
            checkOutput($sformatf("bp%0d number", i), mbnumber, 2);
            cycle();
        end
        runMacroblock(2);
        runMacroblock(3);
        runMacroblock(4);
        runMacroblock(5);

        checkOutput("frame done pulse", frame_done, 1);
        checkOutput("frame done busy", frame_busy, 0);
        checkOutput("frame done valid", mb_valid, 0);
        cycle();
        checkOutput("frame done single", frame_done, 0);
        checkOutput("frame done number", mbnumber, NO_MB);
        cycle();
        checkOutput("idle stays idle", frame_busy, 0);

        // Reset mid-frame in WAIT at MB 3.
        applyStimulus(1, 1, 0, 0);
        cycle();
        applyStimulus(1, 0, 0, 0);
        runMacroblock(0);
        runMacroblock(1);
        runMacroblock(2);
        checkPosition(3);
        applyStimulus(1, 0, 1, 0);
        cycle();
        applyStimulus(1, 0, 0, 0);
        checkOutput("pre-reset busy", frame_busy, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset number", mbnumber, NO_MB);
        checkOutput("async reset mby", mby, 0);
        checkOutput("async reset flags", {avail_left, avail_top, avail_topleft, avail_topright}, 0);
        checkOutput("async reset busy", frame_busy, 0);
        checkOutput("async reset valid", mb_valid, 0);
        #2;
        reset = 1'b1;
        cycle();
        checkOutput("post reset idle", mbnumber, NO_MB);
        applyStimulus(1, 1, 0, 0);
        cycle();
        applyStimulus(1, 0, 0, 0);
        checkPosition(0);

        // Degenerate 1x1 frame.
        d_frame_start = 1'b1;
        cycle();
        d_frame_start = 1'b0;
        #1;
        checkOutput("one valid", d_mb_valid, 1);
        checkOutput("one number", d_mbnumber, 0);
        checkOutput("one flags", {d_avail_left, d_avail_top, d_avail_topleft, d_avail_topright}, 0);
        d_mb_ready = 1'b1;
        cycle();
        d_mb_ready = 1'b0;
        #1;
        checkOutput("one handoff valid", d_mb_valid, 0);
        checkOutput("one handoff busy", d_frame_busy, 1);
        d_mb_done = 1'b1;
        cycle();
        d_mb_done = 1'b0;
        #1;
        checkOutput("one frame done", d_frame_done, 1);
        checkOutput("one done busy", d_frame_busy, 0);
        checkOutput("one mbx", d_mbx, 0);
        cycle();
        checkOutput("one done cleared", d_frame_done, 0);
        checkOutput("one number idle", d_mbnumber, NO_MB);
        d_frame_start = 1'b1;
        cycle();
        d_frame_start = 1'b0;
        #1;
        checkOutput("one restart valid", d_mb_valid, 1);
        checkOutput("one restart number", d_mbnumber, 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
